// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/arb_pick2.sv
// Two-way owner picker: fixed data-over-fetch priority, or round-robin on ties
// when MEM_ARB_RR_EN is defined (the port granted last loses the next tie).
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,    // [1] = data port, [0] = fetch port
  input  owner_t     last,
  output owner_t     owner
);

  always_comb begin
    // NOTE: default first so every path assigns owner and no latch is inferred.
    owner = last;
`ifdef MEM_ARB_RR_EN
    if (req == 2'b11)  owner = (last == OWN_IF) ? OWN_D : OWN_IF;
    else if (req[1])   owner = OWN_D;
    else if (req[0])   owner = OWN_IF;
`else
    if (req[1])        owner = OWN_D;
    else if (req[0])   owner = OWN_IF;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and load/store ports,
// one access in flight at a time. Tie policy selected by MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          clearb,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int             CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_LAT);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_chk
    $error("mem_port_arbiter: MEM_LAT=%0d outside 1..4", MEM_LAT);
  end

  arb_state_t    state;
  owner_t        owner_q;
  owner_t        last_owner;
  owner_t        pick;
  logic          we_q;
  logic [CW-1:0] cnt;

  arb_pick2 u_pick (
    .req   ({d_req, if_req}),
    .last  (last_owner),
    .owner (pick)
  );

  assign busy = (state != IDLE);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clearb) begin
    if (!clearb) begin
      state      <= IDLE;
      owner_q    <= OWN_IF;
      last_owner <= OWN_D;   // "last granted data" makes fetch win the first tie
      we_q       <= 1'b0;
      cnt        <= '0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_gnt      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        IDLE: begin
          // The command is captured straight into the memory-side registers.
          if (if_req || d_req) begin
            owner_q <= pick;
            state   <= ISSUE;
            mem_en  <= 1'b1;
            if (pick == OWN_D) begin
              d_gnt     <= 1'b1;
              mem_we    <= d_we;
              mem_be    <= d_be;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              we_q      <= d_we;
            end else begin
              if_gnt    <= 1'b1;
              mem_be    <= BE_FULL;
              mem_addr  <= if_addr;
              we_q      <= 1'b0;
            end
          end
        end
        ISSUE: begin
          last_owner <= owner_q;
          cnt        <= CNT_ONE;
          state      <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= RESP;
            if (owner_q == OWN_IF) begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end else begin
              d_rdata   <= we_q ? '0 : mem_rdata;
              d_rvalid  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=1 instance for the main
// scenarios and one MEM_LAT=3 instance for latency and mid-access reset.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h2048_0005;
  endfunction

  // ---------------- MEM_LAT = 1 instance ----------------
  logic          clearb = 1'b0;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [3:0]    d_be = 4'h0;
  logic [DW-1:0] d_wdata = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut (
    .clk(clk), .clearb(clearb),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: reads return stored data or mem_f(addr); output is 0 except
  // in the cycle after mem_en, and all-ones after a write.
  logic [31:0] store_q [logic [31:0]];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      logic [31:0] w;
      w = store_q.exists(mem_addr) ? store_q[mem_addr] : mem_f(mem_addr);
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
      store_q[mem_addr] = w;
      mem_rdata <= 32'hFFFF_FFFF;
    end else if (mem_en) begin
      mem_rdata <= store_q.exists(mem_addr) ? store_q[mem_addr] : mem_f(mem_addr);
    end else begin
      mem_rdata <= '0;
    end
  end

  // Event recorder, cycle numbers relative to c0.
  int          c0 = 0, ifg_c, ifr_c, dg_c, dr_c, memen_c, gcnt, we_viol = 0;
  logic [31:0] ifr_d, dr_d, ma_c, mwd_c;
  logic [3:0]  mbe_c, gbits;
  logic        mwe_c;
  bit          auto_drop = 1'b1;

  task automatic clr_rec();
    c0 = cyc; ifg_c = -1; ifr_c = -1; dg_c = -1; dr_c = -1; memen_c = -1;
    gcnt = 0; gbits = '0; ifr_d = '0; dr_d = '0;
  endtask

  always @(negedge clk) begin
    if (mem_we && !mem_en) we_viol++;
    if (if_gnt) begin
      if (ifg_c < 0) ifg_c = cyc - c0;
      gbits = {gbits[2:0], 1'b0}; gcnt++;
      if (auto_drop) if_req = 1'b0;
    end
    if (d_gnt) begin
      if (dg_c < 0) dg_c = cyc - c0;
      gbits = {gbits[2:0], 1'b1}; gcnt++;
      if (auto_drop) d_req = 1'b0;
    end
    if (if_rvalid && ifr_c < 0) begin ifr_c = cyc - c0; ifr_d = if_rdata; end
    if (d_rvalid && dr_c < 0)   begin dr_c = cyc - c0;  dr_d = d_rdata;   end
    if (mem_en && memen_c < 0) begin
      memen_c = cyc - c0; ma_c = mem_addr; mbe_c = mem_be; mwe_c = mem_we; mwd_c = mem_wdata;
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while ((busy || if_req || d_req) && n < 200);
    if (n >= 200) check({tag, "_timeout"}, 1, 0);
  endtask

  // ---------------- MEM_LAT = 3 instance ----------------
  logic          clearb3 = 1'b0, if_req3 = 1'b0;
  logic [AW-1:0] if_addr3 = '0;
  logic          d_req3 = 1'b0, d_we3 = 1'b0;
  logic [3:0]    d_be3 = 4'h0;
  logic [AW-1:0] d_addr3 = '0;
  logic [DW-1:0] d_wdata3 = '0;
  logic          if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3;
  logic [DW-1:0] if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [3:0]    mem_be3;
  logic [AW-1:0] mem_addr3;
  logic [31:0]   p3 [3];

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) dut3 (
    .clk(clk), .clearb(clearb3),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_be(d_be3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  always @(posedge clk) begin
    p3[0] <= mem_en3 ? mem_f(mem_addr3) : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  int          c03 = 0, g3_c, r3_c, side3 = 0;
  logic [31:0] r3_d;

  task automatic clr3();
    c03 = cyc; g3_c = -1; r3_c = -1; r3_d = '0;
  endtask

  always @(negedge clk) begin
    if (if_gnt3) begin if (g3_c < 0) g3_c = cyc - c03; if_req3 = 1'b0; end
    if (if_rvalid3 && r3_c < 0) begin r3_c = cyc - c03; r3_d = if_rdata3; end
    if (d_gnt3 || d_rvalid3 || mem_we3 || (|d_rdata3) || (|mem_wdata3) || (mem_be3 == 4'h0 && mem_en3))
      side3++;
  end

  task automatic wait_idle3(input string tag);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while ((busy3 || if_req3) && n < 200);
    if (n >= 200) check({tag, "_timeout"}, 1, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    clr_rec();
    clr3();

    // 1: reset held 2 cycles with both requests high
    @(negedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0040_0000;
    d_req  = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1001_0000;
    repeat (2) begin @(negedge clk); #1; end
    check("rst_ctrl", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, mem_be, busy}, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    clr_rec();
    clearb = 1'b1;
    wait_idle("t1");
`ifdef MEM_ARB_RR_EN
    check("t1_first_if_gnt", ifg_c, 1);
    check("t1_second_d_gnt", dg_c, 5);
`else
    check("t1_first_d_gnt", dg_c, 1);
    check("t1_second_if_gnt", ifg_c, 5);
`endif

    // 2: single fetch
    clr_rec();
    if_req = 1'b1; if_addr = 32'h0040_0000;
    wait_idle("t2");
    check("t2_if_gnt_cyc", ifg_c, 1);
    check("t2_mem_en_cyc", memen_c, 1);
    check("t2_mem_addr", ma_c, 32'h0040_0000);
    check("t2_mem_be", mbe_c, 4'hF);
    check("t2_mem_we", mwe_c, 0);
    check("t2_if_rvalid_cyc", ifr_c, 3);
    check("t2_if_rdata", ifr_d, 32'h2008_0005);
    check("t2_no_d_gnt", dg_c, -1);

    // 3: simultaneous fetch and load, data port served first
    clr_rec();
    if_req = 1'b1; if_addr = 32'h0040_0010;
    d_req  = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1001_0000;
    wait_idle("t3");
    check("t3_d_gnt_cyc", dg_c, 1);
    check("t3_d_rvalid_cyc", dr_c, 3);
    check("t3_d_rdata", dr_d, 32'h3049_0005);
    check("t3_if_gnt_cyc", ifg_c, 5);
    check("t3_if_rvalid_cyc", ifr_c, 7);
    check("t3_if_rdata", ifr_d, 32'h2008_0015);
    check("t3_if_rdata_hold", if_rdata, 32'h2008_0015);

    // 4: both held across 4 accesses after a fresh reset
    @(negedge clk); #1; clearb = 1'b0;
    @(negedge clk); #1; clearb = 1'b1;
    clr_rec();
    auto_drop = 1'b0;
    if_req = 1'b1; if_addr = 32'h0040_0020;
    d_req  = 1'b1; d_addr = 32'h1001_0008;
    for (int n = 0; n < 100 && gcnt < 4; n++) begin @(negedge clk); #1; end
    if_req = 1'b0; d_req = 1'b0; auto_drop = 1'b1;
    check("t4_grant_count", gcnt, 4);
`ifdef MEM_ARB_RR_EN
    check("t4_grant_order", gbits, 4'b0101);
`else
    check("t4_grant_order", gbits, 4'b1111);
`endif
    wait_idle("t4");

    // 5: partial store then read back
    clr_rec();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h1001_0004;
    wait_idle("t5");
    check("t5_d_gnt_cyc", dg_c, 1);
    check("t5_mem_we", mwe_c, 1);
    check("t5_mem_be", mbe_c, 4'b0011);
    check("t5_mem_wdata", mwd_c, 32'hDEAD_BEEF);
    check("t5_mem_addr", ma_c, 32'h1001_0004);
    check("t5_d_rvalid_cyc", dr_c, 3);
    check("t5_d_rdata_store", dr_d, 0);
    clr_rec();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
    wait_idle("t5b");
    check("t5_load_back", dr_d, 32'h3049_BEEF);
    check("we_only_with_en", we_viol, 0);

    // 6: MEM_LAT = 3, then reset during WAIT, then a clean access
    clearb3 = 1'b1;
    @(negedge clk); #1;
    clr3();
    if_req3 = 1'b1; if_addr3 = 32'h0000_1000;
    wait_idle3("t6a");
    check("t6_gnt_cyc", g3_c, 1);
    check("t6_rvalid_cyc", r3_c, 5);
    check("t6_rdata", r3_d, 32'h2048_1005);
    clr3();
    if_req3 = 1'b1; if_addr3 = 32'h0000_2000;
    repeat (2) begin @(negedge clk); #1; end
    clearb3 = 1'b0;
    #1 check("t6_busy_in_reset", busy3, 0);
    @(negedge clk); #1; clearb3 = 1'b1;
    repeat (8) begin @(negedge clk); #1; end
    check("t6_abort_gnt_cyc", g3_c, 1);
    check("t6_abort_no_rvalid", r3_c, -1);
    check("t6_abort_idle", busy3, 0);
    clr3();
    if_req3 = 1'b1; if_addr3 = 32'h0000_3000;
    wait_idle3("t6c");
    check("t6_after_rvalid_cyc", r3_c, 5);
    check("t6_after_rdata", r3_d, 32'h2048_3005);
    check("t6_no_data_side", side3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
